// File: rtl/instr_pkg.sv
// Shared definitions for the instruction encoder: op kinds, opcode/funct
// field values and the immediate chunk limit used by ADDI/SUBI expansion.
package instr_pkg;

    localparam int MW        = 9;
    localparam int AW        = 8;
    localparam int IMM_CHUNK = 31;

    typedef enum logic [4:0] {
        OP_ADD  = 5'd0,
        OP_SUB  = 5'd1,
        OP_LDR  = 5'd2,
        OP_STR  = 5'd3,
        OP_LB   = 5'd4,
        OP_SUBI = 5'd5,
        OP_ADDI = 5'd6,
        OP_BEQ  = 5'd7,
        OP_BNE  = 5'd8,
        OP_BLT  = 5'd9,
        OP_BLE  = 5'd10,
        OP_LSL  = 5'd11,
        OP_ASR  = 5'd12,
        OP_LSR  = 5'd13,
        OP_NOT  = 5'd14,
        OP_AND  = 5'd15,
        OP_XOR  = 5'd16,
        OP_RXOR = 5'd17,
        OP_OR   = 5'd18,
        OP_MOV  = 5'd19
    } op_e;

    typedef enum logic {
        ST_IDLE,
        ST_EXPAND
    } state_e;

    localparam logic [2:0] OPC_ALU  = 3'b000;
    localparam logic [2:0] OPC_LB   = 3'b001;
    localparam logic [2:0] OPC_SUBI = 3'b010;
    localparam logic [2:0] OPC_ADDI = 3'b011;
    localparam logic [2:0] OPC_BR   = 3'b100;
    localparam logic [2:0] OPC_MOV  = 3'b101;
    localparam logic [2:0] OPC_SH   = 3'b110;
    localparam logic [2:0] OPC_LOG  = 3'b111;

    localparam logic [1:0] F_ADD  = 2'b00;
    localparam logic [1:0] F_SUB  = 2'b01;
    localparam logic [1:0] F_LDR  = 2'b10;
    localparam logic [1:0] F_STR  = 2'b11;
    localparam logic [1:0] F_BEQ  = 2'b00;
    localparam logic [1:0] F_BNE  = 2'b01;
    localparam logic [1:0] F_BLT  = 2'b10;
    localparam logic [1:0] F_BLE  = 2'b11;
    localparam logic [1:0] F_LSL  = 2'b00;
    localparam logic [1:0] F_ASR  = 2'b01;
    localparam logic [1:0] F_LSR  = 2'b10;
    localparam logic [1:0] F_NOT  = 2'b11;
    localparam logic [1:0] F_AND  = 2'b00;
    localparam logic [1:0] F_XOR  = 2'b01;
    localparam logic [1:0] F_RXOR = 2'b10;
    localparam logic [1:0] F_OR   = 2'b11;

    // Largest slice of an immediate that a single ADDI/SUBI word can carry.
    function automatic logic [4:0] chunk_of(input logic [7:0] v);
        return (v > 8'(IMM_CHUNK)) ? 5'(IMM_CHUNK) : v[4:0];
    endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Combinational field packer: maps one symbolic op onto the 9-bit machine
// word layout, flagging ops whose fields do not fit their encoding.
module instr_field_pack
    import instr_pkg::*;
(
    input  logic [4:0]    i_op,
    input  logic [3:0]    i_rd,
    input  logic [3:0]    i_rs,
    input  logic [7:0]    i_imm,
    input  logic [4:0]    i_chunk,
    output logic [MW-1:0] o_word,
    output logic          o_illegal
);

    always_comb begin
        o_word    = '0;
        o_illegal = 1'b0;
        case (i_op)
            OP_ADD:  o_word = {OPC_ALU, F_ADD, i_rd};
            OP_SUB:  o_word = {OPC_ALU, F_SUB, i_rd};
            OP_LDR:  o_word = {OPC_ALU, F_LDR, i_rd};
            OP_STR:  o_word = {OPC_ALU, F_STR, i_rd};
            OP_LB: begin
                if (i_rd > 4'd1 || i_imm[7:5] != 3'd0) o_illegal = 1'b1;
                else                                   o_word = {OPC_LB, i_imm[4:0], i_rd[0]};
            end
            OP_SUBI: o_word = {OPC_SUBI, i_chunk, 1'b0};
            OP_ADDI: o_word = {OPC_ADDI, i_chunk, 1'b0};
            OP_BEQ, OP_BNE, OP_BLT, OP_BLE: begin
                if (i_imm[7:4] != 4'd0) o_illegal = 1'b1;
                else if (i_op == OP_BEQ) o_word = {OPC_BR, F_BEQ, i_imm[3:0]};
                else if (i_op == OP_BNE) o_word = {OPC_BR, F_BNE, i_imm[3:0]};
                else if (i_op == OP_BLT) o_word = {OPC_BR, F_BLT, i_imm[3:0]};
                else                     o_word = {OPC_BR, F_BLE, i_imm[3:0]};
            end
            OP_LSL:  o_word = {OPC_SH,  F_LSL,  i_rd};
            OP_ASR:  o_word = {OPC_SH,  F_ASR,  i_rd};
            OP_LSR:  o_word = {OPC_SH,  F_LSR,  i_rd};
            OP_NOT:  o_word = {OPC_SH,  F_NOT,  i_rd};
            OP_AND:  o_word = {OPC_LOG, F_AND,  i_rd};
            OP_XOR:  o_word = {OPC_LOG, F_XOR,  i_rd};
            OP_RXOR: o_word = {OPC_LOG, F_RXOR, i_rd};
            OP_OR:   o_word = {OPC_LOG, F_OR,   i_rd};
            // MOV has two forms: a full 4-bit rs with 1-bit rd, or the reverse.
            OP_MOV: begin
                if (i_rd <= 4'd1)      o_word = {OPC_MOV, 1'b0, i_rd[0], i_rs};
                else if (i_rs <= 4'd1) o_word = {OPC_MOV, 1'b1, i_rd, i_rs[0]};
                else                   o_illegal = 1'b1;
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Streaming instruction encoder: accepts symbolic ops, splits large ADDI/SUBI
// immediates into several words, and emits each word with its memory address.
module instr_encoder
    import instr_pkg::*;
(
    input  logic          clk,
    input  logic          reset_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    in_op,
    input  logic [3:0]    in_rd,
    input  logic [3:0]    in_rs,
    input  logic [7:0]    in_imm,
    input  logic          addr_clr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [MW-1:0] out_word,
    output logic [AW-1:0] out_addr,
    output logic          err,
    output logic          busy
);

    state_e        r_state;
    logic [7:0]    r_rem;
    logic [4:0]    r_op;
    logic          r_out_valid;
    logic [MW-1:0] r_out_word;
    logic [AW-1:0] r_out_addr;
    logic          r_err;

    logic          w_expand;
    logic          w_out_hs;
    logic          w_accept;
    logic          w_is_imm;
    logic [4:0]    w_pack_op;
    logic [7:0]    w_src;
    logic [4:0]    w_chunk;
    logic [7:0]    w_rem_next;
    logic [MW-1:0] w_word;
    logic          w_illegal;

    assign w_expand   = (r_state == ST_EXPAND);
    assign w_out_hs   = r_out_valid && out_ready;
    assign in_ready   = (r_state == ST_IDLE) && (!r_out_valid || out_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_is_imm   = (in_op == OP_ADDI) || (in_op == OP_SUBI);

    // During expansion the packer is fed the latched op and the remainder.
    assign w_pack_op  = w_expand ? r_op  : in_op;
    assign w_src      = w_expand ? r_rem : in_imm;
    assign w_chunk    = chunk_of(w_src);
    assign w_rem_next = w_src - {3'd0, w_chunk};

    instr_field_pack u_pack (
        .i_op      (w_pack_op),
        .i_rd      (in_rd),
        .i_rs      (in_rs),
        .i_imm     (in_imm),
        .i_chunk   (w_chunk),
        .o_word    (w_word),
        .o_illegal (w_illegal)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_rem       <= '0;
            r_op        <= '0;
            r_out_valid <= 1'b0;
            r_out_word  <= '0;
            r_out_addr  <= '0;
            r_err       <= 1'b0;
        end else begin
            r_err <= w_accept && w_illegal;

            if (addr_clr)      r_out_addr <= '0;
            else if (w_out_hs) r_out_addr <= r_out_addr + 1'b1;

            case (r_state)
                ST_IDLE: begin
                    if (w_accept && !w_illegal) begin
                        r_out_valid <= 1'b1;
                        r_out_word  <= w_word;
                        if (w_is_imm && w_rem_next != 8'd0) begin
                            r_state <= ST_EXPAND;
                            r_rem   <= w_rem_next;
                            r_op    <= in_op;
                        end
                    end else if (w_out_hs) begin
                        r_out_valid <= 1'b0;
                    end
                end
                ST_EXPAND: begin
                    // out_valid stays high; each handshake loads the next chunk.
                    if (w_out_hs) begin
                        r_out_word <= w_word;
                        r_rem      <= w_rem_next;
                        if (w_rem_next == 8'd0) r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_word  = r_out_word;
    assign out_addr  = r_out_addr;
    assign err       = r_err;
    assign busy      = w_expand;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed ops push expected words into a
// queue; a negedge monitor pops and compares on every output handshake.
module tb_instr_encoder;
    import instr_pkg::*;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    in_op;
    logic [3:0]    in_rd;
    logic [3:0]    in_rs;
    logic [7:0]    in_imm;
    logic          addr_clr;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [MW-1:0] out_word;
    logic [AW-1:0] out_addr;
    logic          err;
    logic          busy;

    typedef struct packed {
        logic [8:0] word;
        logic [7:0] addr;
        logic       busy;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         err_exp = 0;
    int         err_seen = 0;
    logic [7:0] exp_addr = 8'd0;
    logic       toggle_en = 1'b0;
    logic       ready_level = 1'b1;

    instr_encoder dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rd     (in_rd),
        .in_rs     (in_rs),
        .in_imm    (in_imm),
        .addr_clr  (addr_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_addr  (out_addr),
        .err       (err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Sink: either holds a fixed ready level or toggles every cycle.
    initial begin : sink
        forever begin
            @(posedge clk);
            #1;
            if (toggle_en) out_ready = ~out_ready;
            else           out_ready = ready_level;
        end
    end

    initial begin : monitor
        exp_t       e;
        logic       prev_stall;
        logic [8:0] prev_word;
        logic [7:0] prev_addr;
        prev_stall = 1'b0;
        prev_word  = '0;
        prev_addr  = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    checks++;
                    if (!out_valid || out_word != prev_word || out_addr != prev_addr) begin
                        errors++;
                        $display("FAIL hold: valid=%b word=%h addr=%0d, required valid=1 word=%h addr=%0d",
                                 out_valid, out_word, out_addr, prev_word, prev_addr);
                    end
                end
                if (out_valid && out_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_word: word=%h addr=%0d, required no word", out_word, out_addr);
                    end else begin
                        e = exp_q.pop_front();
                        if (out_word != e.word || out_addr != e.addr || busy != e.busy) begin
                            errors++;
                            $display("FAIL word: word=%h addr=%0d busy=%b, required word=%h addr=%0d busy=%b",
                                     out_word, out_addr, busy, e.word, e.addr, e.busy);
                        end else begin
                            $display("word %h addr %0d busy %b", out_word, out_addr, busy);
                        end
                    end
                end
                if (err) begin
                    checks++;
                    err_seen++;
                    if (err_seen > err_exp) begin
                        errors++;
                        $display("FAIL unexpected_err: err pulses=%0d, required %0d", err_seen, err_exp);
                    end else begin
                        $display("err pulse %0d", err_seen);
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_word  = out_word;
                prev_addr  = out_addr;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic expect_word(input logic [8:0] w, input logic b);
        exp_q.push_back({w, exp_addr, b});
        exp_addr = exp_addr + 8'd1;
    endtask

    task automatic expect_err();
        err_exp++;
    endtask

    // Present one op and hold it until the encoder takes it (bounded).
    task automatic send(input logic [4:0] op, input logic [3:0] rd, input logic [3:0] rs,
                        input logic [7:0] imm);
        int n;
        bit acc;
        n   = 0;
        acc = 1'b0;
        in_op    = op;
        in_rd    = rd;
        in_rs    = rs;
        in_imm   = imm;
        in_valid = 1'b1;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: op=%0d not accepted in 200 cycles, required acceptance", op);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d words pending, required 0", exp_q.size());
        end
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin : driver
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_op    = '0;
        in_rd    = '0;
        in_rs    = '0;
        in_imm   = '0;
        addr_clr = 1'b0;
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_word",  32'(out_word),  32'd0);
        chk("rst_out_addr",  32'(out_addr),  32'd0);
        chk("rst_err",       32'(err),       32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Single-word ALU / shift / logic ops, back to back.
        expect_word(9'h005, 1'b0); send(OP_ADD,  4'd5,  4'd0, 8'd0);
        expect_word(9'h013, 1'b0); send(OP_SUB,  4'd3,  4'd0, 8'd0);
        expect_word(9'h02F, 1'b0); send(OP_LDR,  4'd15, 4'd0, 8'd0);
        expect_word(9'h030, 1'b0); send(OP_STR,  4'd0,  4'd0, 8'd0);
        expect_word(9'h182, 1'b0); send(OP_LSL,  4'd2,  4'd0, 8'd0);
        expect_word(9'h193, 1'b0); send(OP_ASR,  4'd3,  4'd0, 8'd0);
        expect_word(9'h1A8, 1'b0); send(OP_LSR,  4'd8,  4'd0, 8'd0);
        expect_word(9'h1B1, 1'b0); send(OP_NOT,  4'd1,  4'd0, 8'd0);
        expect_word(9'h1C4, 1'b0); send(OP_AND,  4'd4,  4'd0, 8'd0);
        expect_word(9'h1D9, 1'b0); send(OP_XOR,  4'd9,  4'd0, 8'd0);
        expect_word(9'h1E0, 1'b0); send(OP_RXOR, 4'd0,  4'd0, 8'd0);
        expect_word(9'h1F7, 1'b0); send(OP_OR,   4'd7,  4'd0, 8'd0);

        // LB and branches, legal and out-of-range.
        expect_word(9'h06B, 1'b0); send(OP_LB, 4'd1, 4'd0, 8'h15);
        expect_err();              send(OP_LB, 4'd2, 4'd0, 8'h00);
        expect_err();              send(OP_LB, 4'd0, 4'd0, 8'h20);
        expect_word(9'h106, 1'b0); send(OP_BEQ, 4'd0, 4'd0, 8'h06);
        expect_word(9'h11F, 1'b0); send(OP_BNE, 4'd0, 4'd0, 8'h0F);
        expect_word(9'h129, 1'b0); send(OP_BLT, 4'd0, 4'd0, 8'h09);
        expect_word(9'h130, 1'b0); send(OP_BLE, 4'd0, 4'd0, 8'h00);
        expect_err();              send(OP_BEQ, 4'd0, 4'd0, 8'h16);

        // MOV forms, unencodable MOV and an undefined op.
        expect_word(9'h167, 1'b0); send(OP_MOV, 4'd3, 4'd1, 8'd0);
        expect_err();              send(OP_MOV, 4'd3, 4'd4, 8'd0);
        expect_word(9'h159, 1'b0); send(OP_MOV, 4'd1, 4'd9, 8'd0);
        expect_word(9'h140, 1'b0); send(OP_MOV, 4'd0, 4'd0, 8'd0);
        expect_err();              send(5'd25,  4'd0, 4'd0, 8'd0);
        expect_word(9'h005, 1'b0); send(OP_ADD, 4'd5, 4'd0, 8'd0);
        drain();

        // Immediate expansion, including chunk boundaries.
        expect_word(9'h0FE, 1'b1); expect_word(9'h0FE, 1'b1);
        expect_word(9'h0FE, 1'b1); expect_word(9'h0CE, 1'b0);
        send(OP_ADDI, 4'd0, 4'd0, 8'd100);
        expect_word(9'h080, 1'b0); send(OP_SUBI, 4'd0, 4'd0, 8'd0);
        expect_word(9'h0BE, 1'b0); send(OP_SUBI, 4'd0, 4'd0, 8'd31);
        expect_word(9'h0BE, 1'b1); expect_word(9'h082, 1'b0);
        send(OP_SUBI, 4'd0, 4'd0, 8'd32);
        expect_word(9'h0FE, 1'b1); expect_word(9'h0FE, 1'b0);
        send(OP_ADDI, 4'd0, 4'd0, 8'd62);
        drain();

        // Same expansion with a stalling sink.
        toggle_en = 1'b1;
        expect_word(9'h0FE, 1'b1); expect_word(9'h0FE, 1'b1);
        expect_word(9'h0FE, 1'b1); expect_word(9'h0CE, 1'b0);
        send(OP_ADDI, 4'd0, 4'd0, 8'd100);
        expect_word(9'h1C4, 1'b0); send(OP_AND, 4'd4, 4'd0, 8'd0);
        drain();
        toggle_en = 1'b0;
        @(posedge clk);
        #1;

        // addr_clr coinciding with a handshake.
        expect_word(9'h001, 1'b0); send(OP_ADD, 4'd1, 4'd0, 8'd0);
        addr_clr = 1'b1;
        @(posedge clk);
        #1;
        addr_clr = 1'b0;
        exp_addr = 8'd0;
        drain();
        chk("addr_after_clr", 32'(out_addr), 32'd0);

        // 256 words wrap the pointer; the next lands at address 0.
        for (int i = 0; i < 256; i++) begin
            expect_word({5'd0, 4'(i)}, 1'b0);
            send(OP_ADD, 4'(i), 4'd0, 8'd0);
        end
        expect_word(9'h00A, 1'b0); send(OP_ADD, 4'd10, 4'd0, 8'd0);
        drain();
        chk("addr_after_wrap", 32'(out_addr), 32'd1);

        // Reset in the middle of an ADDI 200 expansion.
        ready_level = 1'b0;
        @(posedge clk);
        #1;
        send(OP_ADDI, 4'd0, 4'd0, 8'd200);
        #1;
        chk("exp_busy",  32'(busy),      32'd1);
        chk("exp_valid", 32'(out_valid), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("abort_valid",    32'(out_valid), 32'd0);
        chk("abort_busy",     32'(busy),      32'd0);
        chk("abort_addr",     32'(out_addr),  32'd0);
        chk("abort_word",     32'(out_word),  32'd0);
        chk("abort_in_ready", 32'(in_ready),  32'd1);
        ready_level = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n  = 1'b1;
        exp_addr = 8'd0;
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        chk("post_abort_valid", 32'(out_valid), 32'd0);
        expect_word(9'h005, 1'b0); send(OP_ADD, 4'd5, 4'd0, 8'd0);
        drain();

        chk("err_pulse_count", 32'(err_seen), 32'(err_exp));
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
